// File: rtl/tcp_tx_scheduler_if.sv
// ----------------------------------------------------------------------------
// tcp_tx_scheduler_if
//   Command and completion bundle between the TCP TX scheduler and the TX
//   packet builder, plus the per-frame update pulses that go to the
//   connection state manager.
//
//   Handshake: a command transfers on any rising clock edge where
//   tx_cmd_valid and tx_cmd_ready are both high. Once tx_cmd_valid rises,
//   tx_cmd_type and tx_cmd_len stay stable and valid stays high until that
//   transfer. tx_cmd_done is a one-cycle pulse from the builder when the
//   frame has left.
//
//   Signals:
//     tx_cmd_valid      scheduler -> builder  command valid
//     tx_cmd_ready      builder -> scheduler  command accepted
//     tx_cmd_type       scheduler -> builder  0 SYN_ACK, 1 FIN_ACK, 2 ACK, 3 DATA
//     tx_cmd_len        scheduler -> builder  payload bytes (0 unless DATA)
//     tx_cmd_done       builder -> scheduler  frame finished pulse
//     seq_advance       scheduler -> manager  sequence increment
//     seq_advance_valid scheduler -> manager  pulse qualifying seq_advance
//     ip_id_inc         scheduler -> manager  pulse: bump IP identification
// ----------------------------------------------------------------------------
interface tcp_tx_scheduler_if;
   logic        tx_cmd_valid;
   logic        tx_cmd_ready;
   logic [1:0]  tx_cmd_type;
   logic [15:0] tx_cmd_len;
   logic        tx_cmd_done;
   logic [31:0] seq_advance;
   logic        seq_advance_valid;
   logic        ip_id_inc;

   modport master (
      output tx_cmd_valid,
      output tx_cmd_type,
      output tx_cmd_len,
      output seq_advance,
      output seq_advance_valid,
      output ip_id_inc,
      input  tx_cmd_ready,
      input  tx_cmd_done
   );

   modport slave (
      input  tx_cmd_valid,
      input  tx_cmd_type,
      input  tx_cmd_len,
      input  seq_advance,
      input  seq_advance_valid,
      input  ip_id_inc,
      output tx_cmd_ready,
      output tx_cmd_done
   );
endinterface

// File: rtl/tcp_tx_scheduler.sv
// ----------------------------------------------------------------------------
// tcp_tx_scheduler
//   Arbitrates SYN-ACK, FIN-ACK, standalone ACK and DATA segments onto the
//   single TX packet builder, one command outstanding at a time. Control
//   requests are latched into pending flags, data is limited by the peer
//   receive window, and a standalone ACK is held back (delayed ACK) so it can
//   ride on a data segment instead.
//
//   Ports:
//     aclk, aresetn     clock, asynchronous active-low reset
//     req_syn_ack       pulse: SYN-ACK owed
//     req_fin           pulse: FIN-ACK owed
//     req_ack           pulse: in-order data received, ACK owed
//     tcp_state         connection state (0 IDLE,1 SYN_RCVD,3 EST,6 CLOSE_WAIT,7 LAST_ACK)
//     data_avail        unsent bytes in the TX buffer
//     seq_local         next local sequence number
//     ack_opposite      highest ACK received from the peer
//     opposite_window   peer advertised window
//     shift_count       peer window scale
//     tx                builder command / update-pulse bundle (master side)
//     busy              high whenever the FSM is not in SEL
//     fsm_state         current FSM state (0 SEL, 1 ISSUE, 2 WAIT)
// ----------------------------------------------------------------------------
module tcp_tx_scheduler #(
   parameter int unsigned MSS       = 1460,
   parameter int unsigned ACK_DELAY = 200,
   parameter int unsigned MAX_SHIFT = 14
) (
   input  logic                      aclk,
   input  logic                      aresetn,
   input  logic                      req_syn_ack,
   input  logic                      req_fin,
   input  logic                      req_ack,
   input  logic [3:0]                tcp_state,
   input  logic [31:0]               data_avail,
   input  logic [31:0]               seq_local,
   input  logic [31:0]               ack_opposite,
   input  logic [15:0]               opposite_window,
   input  logic [7:0]                shift_count,
   tcp_tx_scheduler_if.master        tx,
   output logic                      busy,
   output logic [1:0]                fsm_state
);

   typedef enum logic [1:0] {
      SEL   = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   localparam logic [1:0] T_SYN_ACK = 2'd0;
   localparam logic [1:0] T_FIN_ACK = 2'd1;
   localparam logic [1:0] T_ACK     = 2'd2;
   localparam logic [1:0] T_DATA    = 2'd3;

   localparam int unsigned TW = $clog2(ACK_DELAY + 1);
   localparam logic [TW-1:0] ACK_DELAY_T = TW'(ACK_DELAY);

   state_t        state, state_nxt;
   logic          pend_syn, pend_fin, pend_ack, ack2;
   logic [TW-1:0] ack_timer;
   logic [1:0]    cmd_type, sel_type;
   logic [15:0]   cmd_len, sel_len;
   logic          load;
   logic          seq_adv_v, ip_inc;
   logic [31:0]   seq_adv;

   // ---------------------------------------------------------------------
   // Window arithmetic. inflight uses modulo subtraction so a sequence
   // space wrap between ack_opposite and seq_local is handled naturally.
   // ---------------------------------------------------------------------
   logic [7:0]  shift_eff;
   logic [31:0] win, inflight, room, len_cap, len32;
   logic [15:0] len16;

   assign shift_eff = (shift_count > 8'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : shift_count;
   assign win       = {16'b0, opposite_window} << shift_eff;
   assign inflight  = seq_local - ack_opposite;
   assign room      = (inflight < win) ? (win - inflight) : 32'd0;
   assign len_cap   = (data_avail < 32'(MSS)) ? data_avail : 32'(MSS);
   assign len32     = (room < len_cap) ? room : len_cap;
   assign len16     = 16'(len32);

   // ---------------------------------------------------------------------
   // Eligibility
   // ---------------------------------------------------------------------
   logic st_est, st_close;
   logic elig_syn, elig_fin, elig_data, elig_ack;

   assign st_est    = (tcp_state == 4'd3);
   assign st_close  = (tcp_state == 4'd6) || (tcp_state == 4'd7);
   assign elig_syn  = pend_syn && (tcp_state == 4'd1);
   assign elig_fin  = pend_fin && st_close;
   assign elig_data = st_est && (data_avail != 32'd0) && (room != 32'd0);
   assign elig_ack  = pend_ack && (st_est || st_close) &&
                      ((ack_timer == ACK_DELAY_T) || ack2);

   // ---------------------------------------------------------------------
   // Handshake and clear events
   // ---------------------------------------------------------------------
   logic hs, done_evt, idle_clr, clr_syn, clr_fin, clr_ack;

   assign hs       = (state == ISSUE) && tx.tx_cmd_ready;
   assign done_evt = (state == WAIT) && tx.tx_cmd_done;
   assign idle_clr = (state == SEL) && (tcp_state == 4'd0);
   assign clr_syn  = hs && (cmd_type == T_SYN_ACK);
   assign clr_fin  = hs && (cmd_type == T_FIN_ACK);
   // A DATA segment carries the ACK as well, so it retires pend_ack too.
   assign clr_ack  = hs && ((cmd_type == T_ACK) || (cmd_type == T_DATA));

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) state <= SEL;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      sel_type  = T_ACK;
      sel_len   = 16'd0;
      case (state)
         SEL: begin
            if (elig_syn) begin
               load     = 1'b1;
               sel_type = T_SYN_ACK;
            end else if (elig_fin) begin
               load     = 1'b1;
               sel_type = T_FIN_ACK;
            end else if (elig_data) begin
               load     = 1'b1;
               sel_type = T_DATA;
               sel_len  = len16;
            end else if (elig_ack) begin
               load     = 1'b1;
               sel_type = T_ACK;
            end
            if (load) state_nxt = ISSUE;
         end
         ISSUE:   if (tx.tx_cmd_ready) state_nxt = WAIT;
         WAIT:    if (tx.tx_cmd_done)  state_nxt = SEL;
         default: state_nxt = SEL;
      endcase
   end

   // ---------------------------------------------------------------------
   // Command registers and per-frame update pulses
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cmd_type  <= 2'd0;
         cmd_len   <= 16'd0;
         seq_adv_v <= 1'b0;
         seq_adv   <= 32'd0;
         ip_inc    <= 1'b0;
      end else begin
         if (load) begin
            cmd_type <= sel_type;
            cmd_len  <= sel_len;
         end
         ip_inc    <= done_evt;
         seq_adv_v <= done_evt && (cmd_type != T_ACK);
         if (done_evt && (cmd_type == T_DATA))
            seq_adv <= {16'b0, cmd_len};
         else if (done_evt && (cmd_type != T_ACK))
            seq_adv <= 32'd1;
         else
            seq_adv <= 32'd0;
      end
   end

   // ---------------------------------------------------------------------
   // Pending flags. A request coinciding with its clear keeps the flag set.
   // ---------------------------------------------------------------------
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pend_syn  <= 1'b0;
         pend_fin  <= 1'b0;
         pend_ack  <= 1'b0;
         ack2      <= 1'b0;
         ack_timer <= '0;
      end else if (idle_clr) begin
         pend_syn  <= 1'b0;
         pend_fin  <= 1'b0;
         pend_ack  <= 1'b0;
         ack2      <= 1'b0;
         ack_timer <= '0;
      end else begin
         pend_syn <= req_syn_ack | (pend_syn & ~clr_syn);
         pend_fin <= req_fin     | (pend_fin & ~clr_fin);
         pend_ack <= req_ack     | (pend_ack & ~clr_ack);
         // A second ACK request while one is already owed forces the ACK out.
         if (clr_ack)                ack2 <= 1'b0;
         else if (req_ack && pend_ack) ack2 <= 1'b1;
         // Timer saturates at ACK_DELAY so eligibility is not lost while the
         // builder is busy with another frame.
         if (clr_ack || !pend_ack)
            ack_timer <= '0;
         else if (ack_timer != ACK_DELAY_T)
            ack_timer <= ack_timer + TW'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign tx.tx_cmd_valid      = (state == ISSUE);
   assign tx.tx_cmd_type       = cmd_type;
   assign tx.tx_cmd_len        = cmd_len;
   assign tx.seq_advance       = seq_adv;
   assign tx.seq_advance_valid = seq_adv_v;
   assign tx.ip_id_inc         = ip_inc;
   assign busy                 = (state != SEL);
   assign fsm_state            = state;

endmodule
